mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares one memory request/response port between IFU (read-only fetch) and LSU (load/store).
// - Sits between the core's fetch/LSU stages and the DPI memory model.
// - Accepts one transaction at a time and latches it. Drives it downstream, waits for the
//   response and routes it back to the owner. A transaction with no response is
//   retired by timeout.
// PARAMETERS
// - ADDR_W   32   address width
// - DATA_W   32   data width (wmask width = DATA_W/4, i.e. 8)
// - TIMEOUT  255  max cycles in WAIT before forced error retire (1..65535)
// PORTS
// - clk             in   1       clock, rising edge
// - rst_n           in   1       asynchronous, active-low reset
// - ifu_req_valid   in   1       fetch request
// - ifu_req_ready   out  1       fetch request accepted this cycle
// - ifu_addr        in   ADDR_W  fetch address (read len fixed 4)
// - ifu_resp_valid  out  1       fetch data valid, 1-cycle pulse
// - ifu_rdata       out  DATA_W  fetch data
// - lsu_req_valid   in   1       load/store request
// - lsu_req_ready   out  1       load/store accepted this cycle
// - lsu_wen         in   1       1 = store, 0 = load
// - lsu_addr        in   ADDR_W  load/store address
// - lsu_wdata       in   DATA_W  store data
// - lsu_wmask       in   8       store byte mask
// - lsu_rlen        in   32      load length in bytes (1, 2 or 4)
// - lsu_resp_valid  out  1       load data / store done, 1-cycle pulse
// - lsu_rdata       out  DATA_W  load data (0 for stores)
// - mem_req_valid   out  1       downstream request
// - mem_req_ready   in   1       downstream accepts request
// - mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rlen  out  1/ADDR_W/DATA_W/8/32  latched fields
// - mem_resp_valid  in   1       downstream response; also acks stores
// - mem_rdata       in   DATA_W  downstream read data
// - bus_err         out  1       pulses with resp_valid on a timeout retire
// BEHAVIOUR
// - FSM states: IDLE, REQ, WAIT. Reset: state=IDLE, all outputs 0, counter 0, last_owner=IFU.
// - IDLE, no request pending: all readies 0.
// - IDLE, request pending: grant one requester.
//   - Assert that requester's req_ready combinationally.
//   - Latch addr/wen/wdata/wmask/rlen and the owner.
//   - IFU grants latch wen=0, wmask=0, rlen=4.
//   - Next state: REQ.
// - Tie (both valid) without the macro: LSU wins.
// - REQ: mem_req_valid=1 with the latched fields, held stable.
//   - On mem_req_ready: go to WAIT and clear the counter.
// - WAIT: mem_req_valid=0; the counter increments each cycle.
//   - On mem_resp_valid: owner resp_valid=1 and rdata=mem_rdata in the same cycle
//     (combinational pass). Then go to IDLE.
//   - Store ack: lsu_rdata=0.
//   - Counter reaches TIMEOUT with no response: owner resp_valid=1, rdata=0, bus_err=1.
//     Then go to IDLE.
//   - A response and the timeout in the same cycle: the response wins, bus_err=0.
// - Non-owner resp_valid is always 0. mem_resp_valid is ignored in IDLE and REQ.
// - Minimum latency: accept in cycle 0, mem_req_valid in cycle 1, response no earlier than cycle 2.
//   Back-to-back grants need one IDLE cycle, so there is at most 1 transaction in flight.
// - Requester fields are sampled only at the grant edge; later changes are ignored.
//   Requesters keep valid high until ready.
// - Reset asserted mid-transaction: immediate return to IDLE, outputs 0, transaction dropped,
//   no response issued.
// - Counter width: clog2(TIMEOUT+1). The counter saturates and does not wrap.
// CONFIGURATION
// - MEM_ARB_RR_EN defined: round-robin on ties.
//   - The requester not granted last wins.
//   - last_owner updates on every grant.
//   - last_owner resets to IFU, so the first tie grants LSU.
// - MEM_ARB_RR_EN undefined: fixed priority LSU > IFU; the last_owner register is not built.
// - Single requests behave identically in both builds.
// TESTING
// - Single fetch:
//   - Stimulus: ifu_addr=0x80000000, mem_req_ready=1, mem_resp_valid 2 cycles later with
//     mem_rdata=0x00000413.
//   - Response: ifu_resp_valid pulses once with ifu_rdata=0x00000413, mem_rlen=4, mem_wen=0.
// - Store:
//   - Stimulus: lsu_wen=1, lsu_addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, ack after 3 cycles.
//   - Response: mem fields match the stimulus; lsu_resp_valid pulse with lsu_rdata=0.
// - Tie, 3 consecutive rounds:
//   - Stimulus: both requesters valid every round.
//   - Fixed-priority build: grants LSU, LSU, LSU.
//   - MEM_ARB_RR_EN build: grants LSU, IFU, LSU.
// - Backpressure:
//   - Stimulus: mem_req_ready low for 5 cycles; change lsu_addr after the grant.
//   - Response: mem_req_valid held and mem_addr stays equal to the granted value.
// - Timeout:
//   - Stimulus: TIMEOUT=8, no mem_resp_valid.
//   - Response: 8 cycles after entering WAIT, owner resp_valid=1, rdata=0, bus_err=1; then IDLE.
// - Reset in WAIT:
//   - Stimulus: pull rst_n low.
//   - Response: outputs 0 asynchronously, no resp pulse, and a fetch after release completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (IFU fetch / LSU load-store) arbiter onto a single memory port, one transaction in flight.
// Optional macro MEM_ARB_RR_EN: round-robin on ties; otherwise fixed priority LSU > IFU.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ADDR_W-1:0]     ifu_addr,
   output logic                  ifu_resp_valid,
   output logic [DATA_W-1:0]     ifu_rdata,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic                  lsu_wen,
   input  logic [ADDR_W-1:0]     lsu_addr,
   input  logic [DATA_W-1:0]     lsu_wdata,
   input  logic [DATA_W/4-1:0]   lsu_wmask,
   input  logic [31:0]           lsu_rlen,
   output logic                  lsu_resp_valid,
   output logic [DATA_W-1:0]     lsu_rdata,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_wen,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/4-1:0]   mem_wmask,
   output logic [31:0]           mem_rlen,
   input  logic                  mem_resp_valid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  bus_err
);
   localparam int MASK_W = DATA_W / 4;
   localparam int CNT_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              state, state_nxt;
   logic                grant_any, grant_lsu, owner_lsu, timeout_hit;
   logic [CNT_W-1:0]    cnt;
   logic                wen_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;
   logic [31:0]         rlen_q;

   assign grant_any = (state == IDLE) && (ifu_req_valid || lsu_req_valid);

`ifdef MEM_ARB_RR_EN
   logic last_lsu;

   // On a tie the requester that did not win the previous grant goes first.
   assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         last_lsu <= 1'b0;
      else if (grant_any) last_lsu <= grant_lsu;
   end
`else
   assign grant_lsu = lsu_req_valid;
`endif

   assign timeout_hit = (cnt == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner_lsu <= 1'b0;
         cnt       <= '0;
      end else begin
         state <= state_nxt;
         if (grant_any) owner_lsu <= grant_lsu;
         if (state == REQ)                       cnt <= '0;
         else if (state == WAIT && !timeout_hit) cnt <= cnt + 1'b1;
      end
   end

   // Request payload is only sampled at the grant edge; outputs are gated by state instead of reset.
   always_ff @(posedge clk) begin
      if (grant_any) begin
         if (grant_lsu) begin
            wen_q   <= lsu_wen;
            addr_q  <= lsu_addr;
            wdata_q <= lsu_wdata;
            wmask_q <= lsu_wmask;
            rlen_q  <= lsu_rlen;
         end else begin
            wen_q   <= 1'b0;
            addr_q  <= ifu_addr;
            wdata_q <= '0;
            wmask_q <= '0;
            rlen_q  <= 32'd4;
         end
      end
   end

   assign mem_wen   = (state == REQ) ? wen_q   : 1'b0;
   assign mem_addr  = (state == REQ) ? addr_q  : '0;
   assign mem_wdata = (state == REQ) ? wdata_q : '0;
   assign mem_wmask = (state == REQ) ? wmask_q : '0;
   assign mem_rlen  = (state == REQ) ? rlen_q  : 32'd0;

   always_comb begin
      state_nxt      = state;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      mem_req_valid  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_rdata      = '0;
      lsu_rdata      = '0;
      bus_err        = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_any) begin
               lsu_req_ready = grant_lsu;
               ifu_req_ready = !grant_lsu;
               state_nxt     = REQ;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nxt = WAIT;
         end
         WAIT: begin
            // A real response beats a simultaneous timeout.
            if (mem_resp_valid || timeout_hit) begin
               state_nxt = IDLE;
               bus_err   = !mem_resp_valid;
               if (owner_lsu) begin
                  lsu_resp_valid = 1'b1;
                  lsu_rdata      = (mem_resp_valid && !wen_q) ? mem_rdata : '0;
               end else begin
                  ifu_resp_valid = 1'b1;
                  ifu_rdata      = mem_resp_valid ? mem_rdata : '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions against a
// transaction-level model of grant order, latched fields, response routing and timeout.
module tb_mem_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TO     = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid;
   logic [31:0] ifu_addr = 0, ifu_rdata;
   logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_resp_valid;
   logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rlen = 4, lsu_rdata;
   logic [7:0]  lsu_wmask = 0;
   logic        mem_req_valid, mem_req_ready = 0, mem_wen, mem_resp_valid = 0, bus_err;
   logic [31:0] mem_addr, mem_wdata, mem_rlen, mem_rdata = 0;
   logic [7:0]  mem_wmask;

   int n_err = 0;
   int n_checks = 0;
   bit m_last_lsu = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_rlen(lsu_rlen),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rlen(mem_rlen),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Arbitration rule of the reference model.
   function automatic bit pick_lsu(input bit iv, input bit lv);
      if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
         return !m_last_lsu;
`else
         return 1'b1;
`endif
      end
      return lv;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_mreq"}, mem_req_valid, 0);
      check({tag, "_resp"}, {ifu_resp_valid, lsu_resp_valid, bus_err}, 0);
      check({tag, "_fields"}, {mem_wen, mem_addr, mem_wmask}, 0);
   endtask

   // One full transaction: grant, d1 cycles of backpressure, response after d2 WAIT cycles
   // (d2 > TO means no response, so the timeout must retire it).
   task automatic do_txn(input bit iv, input bit lv, input int d1, input int d2,
                         input logic [31:0] rsp, output bit g_lsu);
      bit          w;
      logic        e_wen;
      logic [31:0] e_addr, e_wdata, e_rlen, e_rd;
      logic [7:0]  e_wmask;
      ifu_req_valid  = iv;
      lsu_req_valid  = lv;
      mem_req_ready  = 0;
      mem_resp_valid = $urandom_range(0, 1);
      w = pick_lsu(iv, lv);
      if (w) begin
         e_wen = lsu_wen; e_addr = lsu_addr; e_wdata = lsu_wdata; e_wmask = lsu_wmask; e_rlen = lsu_rlen;
      end else begin
         e_wen = 0; e_addr = ifu_addr; e_wdata = 0; e_wmask = 0; e_rlen = 4;
      end
      @(negedge clk);
      g_lsu = lsu_req_ready;
      check("grant_lsu_rdy", lsu_req_ready, w);
      check("grant_ifu_rdy", ifu_req_ready, !w);
      check("idle_mreq", mem_req_valid, 0);
      check("idle_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
      @(posedge clk); #1;
      m_last_lsu = w;
      if (w) begin
         lsu_req_valid = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
         lsu_wen = ~lsu_wen; lsu_rlen = $urandom;
      end else begin
         ifu_req_valid = 0; ifu_addr = $urandom;
      end
      for (int c = 0; c <= d1; c++) begin
         mem_req_ready  = (c == d1);
         mem_resp_valid = $urandom_range(0, 1);
         mem_rdata      = $urandom;
         @(negedge clk);
         check("req_valid", mem_req_valid, 1);
         check("req_addr", mem_addr, e_addr);
         check("req_wen", mem_wen, e_wen);
         check("req_wdata", mem_wdata, e_wdata);
         check("req_wmask", mem_wmask, e_wmask);
         check("req_rlen", mem_rlen, e_rlen);
         check("req_rdy", {ifu_req_ready, lsu_req_ready}, 0);
         check("req_resp", {ifu_resp_valid, lsu_resp_valid, bus_err}, 0);
         @(posedge clk); #1;
      end
      mem_req_ready = 0;
      for (int k = 0; k <= TO; k++) begin
         bit rv, hit;
         rv  = (k == d2);
         hit = rv || (k == TO);
         mem_resp_valid = rv;
         mem_rdata      = rv ? rsp : $urandom;
         e_rd = (rv && !(w && e_wen)) ? rsp : 32'd0;
         @(negedge clk);
         check("wait_mreq", mem_req_valid, 0);
         check("ifu_resp", ifu_resp_valid, hit && !w);
         check("lsu_resp", lsu_resp_valid, hit && w);
         check("bus_err", bus_err, hit && !rv);
         if (hit && !w) check("ifu_rdata", ifu_rdata, e_rd);
         if (hit && w)  check("lsu_rdata", lsu_rdata, e_rd);
         @(posedge clk); #1;
         if (hit) break;
      end
      mem_resp_valid = 0;
   endtask

   initial begin
      bit g;
      bit ifu_pend = 0, lsu_pend = 0;
      bit exp_tie [3];
      #1;
      check_quiet("reset");
      check("reset_rdy", {ifu_req_ready, lsu_req_ready}, 0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_norq_rdy", {ifu_req_ready, lsu_req_ready}, 0);
      check_quiet("idle_norq");
      @(posedge clk); #1;

      // Tie rounds straight out of reset.
`ifdef MEM_ARB_RR_EN
      exp_tie = '{1'b1, 1'b0, 1'b1};
`else
      exp_tie = '{1'b1, 1'b1, 1'b1};
`endif
      ifu_addr = 32'h8000_0100;
      for (int r = 0; r < 3; r++) begin
         lsu_wen = 0; lsu_addr = 32'h8000_2000 + r * 4; lsu_rlen = 4;
         do_txn(1, 1, 0, 1, 32'h1111_0000 + r, g);
         check($sformatf("tie_round%0d", r), g, exp_tie[r]);
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      // Drain any IFU request left pending by the tie rounds.
      if (!g || exp_tie[2]) begin
         ifu_addr = 32'h8000_0200;
         do_txn(1, 0, 0, 0, 32'h2222_2222, g);
      end

      // Single fetch.
      ifu_addr = 32'h8000_0000;
      do_txn(1, 0, 0, 0, 32'h0000_0413, g);

      // Store acked after 3 cycles.
      lsu_wen = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; lsu_rlen = 4;
      do_txn(0, 1, 0, 1, 32'h5555_AAAA, g);

      // Backpressure with request fields scrambled after grant.
      lsu_wen = 0; lsu_addr = 32'h8000_3000; lsu_rlen = 2;
      do_txn(0, 1, 5, 2, 32'h0000_BEEF, g);

      // Timeout, then response exactly on the timeout cycle.
      ifu_addr = 32'h8000_4000;
      do_txn(1, 0, 1, TO + 5, 32'h0, g);
      lsu_wen = 0; lsu_addr = 32'h8000_5000; lsu_rlen = 1;
      do_txn(0, 1, 0, TO + 5, 32'h0, g);
      ifu_addr = 32'h8000_6000;
      do_txn(1, 0, 0, TO, 32'h1234_5678, g);

      // Reset while in WAIT.
      ifu_addr = 32'h8000_7000; ifu_req_valid = 1;
      @(posedge clk); #1; ifu_req_valid = 0; mem_req_ready = 1;
      @(posedge clk); #1; mem_req_ready = 0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 0; mem_resp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
      #1;
      check_quiet("rst_async");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_quiet("rst_hold");
      end
      rst_n = 1; mem_resp_valid = 0; m_last_lsu = 0;
      @(posedge clk); #1;
      ifu_addr = 32'h8000_8000;
      do_txn(1, 0, 0, 0, 32'h0000_0013, g);

      // Randomized traffic with pending requesters held until granted.
      for (int t = 0; t < 60; t++) begin
         if (!ifu_pend && $urandom_range(0, 1)) begin
            ifu_pend = 1; ifu_addr = $urandom;
         end
         if (!lsu_pend && $urandom_range(0, 1)) begin
            lsu_pend = 1; lsu_addr = $urandom; lsu_wen = $urandom_range(0, 1);
            lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
            case ($urandom_range(0, 2))
               0: lsu_rlen = 1;
               1: lsu_rlen = 2;
               default: lsu_rlen = 4;
            endcase
         end
         if (!ifu_pend && !lsu_pend) begin
            ifu_req_valid = 0; lsu_req_valid = 0;
            @(negedge clk);
            check("rnd_idle_rdy", {ifu_req_ready, lsu_req_ready}, 0);
            @(posedge clk); #1;
         end else begin
            do_txn(ifu_pend, lsu_pend, $urandom_range(0, 3), $urandom_range(0, TO + 2), $urandom, g);
            if (g) lsu_pend = 0;
            else   ifu_pend = 0;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
